// File: rtl/linear_interpolator.sv
// Linear interpolating upsampler: emits 2^ABITS evenly spaced samples between
// successive input samples, one per downstream tick.
module linear_interpolator #(
  parameter int NBITS = 32,
  parameter int ABITS = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [NBITS-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             tick,
  output logic [NBITS-1:0] out_data,
  output logic             out_valid,
  output logic             underrun
);

  localparam int ACCW = NBITS + ABITS + 1;
  localparam int SW   = NBITS + 1;
  localparam logic [ABITS-1:0] PHASE_ZERO = {ABITS{1'b0}};
  localparam logic [ABITS-1:0] PHASE_ONE  = ABITS'(1);
  localparam logic [ABITS-1:0] PHASE_LAST = {ABITS{1'b1}};

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [NBITS-1:0] next_q, next_d;
  logic             next_full_q, next_full_d;
  logic [ACCW-1:0]  acc_q, acc_d;
  logic [SW-1:0]    step_q, step_d;
  logic [NBITS-1:0] anchor_q, anchor_d;
  logic [NBITS-1:0] target_q, target_d;
  logic [ABITS-1:0] phase_q, phase_d;
  logic [NBITS-1:0] out_data_q, out_data_d;
  logic             out_valid_q, out_valid_d;
  logic             underrun_q, underrun_d;
  logic             accept_s;
  logic             consume_s;

  // A sample on the fixed-point grid: value with ABITS zero fraction bits.
  function automatic logic [ACCW-1:0] scale_up(input logic [NBITS-1:0] v);
    return {1'b0, v, {ABITS{1'b0}}};
  endfunction

  // Signed per-tick increment; the extra bit keeps full-scale swings exact.
  function automatic logic [SW-1:0] seg_step(input logic [NBITS-1:0] tgt,
                                             input logic [NBITS-1:0] anc);
    return {1'b0, tgt} - {1'b0, anc};
  endfunction

  function automatic logic [ACCW-1:0] sext_step(input logic [SW-1:0] s);
    return {{ABITS{s[SW-1]}}, s};
  endfunction

  assign in_ready  = !next_full_q;
  assign accept_s  = in_valid && !next_full_q;
  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign underrun  = underrun_q;

  // Next-state, segment loading and output generation.
  always_comb begin
    state_d     = state_q;
    next_d      = next_q;
    next_full_d = next_full_q;
    acc_d       = acc_q;
    step_d      = step_q;
    anchor_d    = anchor_q;
    target_d    = target_q;
    phase_d     = phase_q;
    out_data_d  = out_data_q;
    out_valid_d = 1'b0;
    underrun_d  = 1'b0;
    consume_s   = 1'b0;

    case (state_q)
      ST_EMPTY: begin
        if (next_full_q) begin
          anchor_d  = next_q;
          acc_d     = scale_up(next_q);
          consume_s = 1'b1;
          state_d   = ST_WAIT;
        end else begin
          state_d = ST_EMPTY;
        end
      end

      ST_WAIT: begin
        if (tick) begin
          out_data_d  = anchor_q;
          out_valid_d = 1'b1;
        end else begin
          out_valid_d = 1'b0;
        end
        if (next_full_q) begin
          step_d    = seg_step(next_q, anchor_q);
          target_d  = next_q;
          consume_s = 1'b1;
          state_d   = ST_RUN;
          if (tick) begin
            acc_d   = acc_q + sext_step(seg_step(next_q, anchor_q));
            phase_d = PHASE_ONE;
          end else begin
            phase_d = PHASE_ZERO;
          end
        end else if (tick) begin
          underrun_d = 1'b1;
        end else begin
          underrun_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (tick) begin
          out_data_d  = acc_q[NBITS+ABITS-1:ABITS];
          out_valid_d = 1'b1;
          acc_d       = acc_q + sext_step(step_q);
          phase_d     = phase_q + PHASE_ONE;
          // Snap to the exact target at segment end; chain the next one if ready.
          if (phase_q == PHASE_LAST) begin
            anchor_d = target_q;
            acc_d    = scale_up(target_q);
            phase_d  = PHASE_ZERO;
            if (next_full_q) begin
              step_d    = seg_step(next_q, target_q);
              target_d  = next_q;
              consume_s = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_RUN;
          end
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_EMPTY;
      end
    endcase

    // Consumption only happens when full and acceptance only when empty.
    if (consume_s) begin
      next_full_d = 1'b0;
    end else if (accept_s) begin
      next_full_d = 1'b1;
      next_d      = in_data;
    end else begin
      next_full_d = next_full_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_EMPTY;
      next_q      <= {NBITS{1'b0}};
      next_full_q <= 1'b0;
      acc_q       <= {ACCW{1'b0}};
      step_q      <= {SW{1'b0}};
      anchor_q    <= {NBITS{1'b0}};
      target_q    <= {NBITS{1'b0}};
      phase_q     <= PHASE_ZERO;
      out_data_q  <= {NBITS{1'b0}};
      out_valid_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      next_q      <= next_d;
      next_full_q <= next_full_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      anchor_q    <= anchor_d;
      target_q    <= target_d;
      phase_q     <= phase_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      underrun_q  <= underrun_d;
    end
  end

endmodule

// File: tb/tb_linear_interpolator.sv
// Bench for linear_interpolator (NBITS=16, ABITS=2): directed cases plus random
// traffic, checked against a queue/formula reference model.
module tb_linear_interpolator;

  localparam int NB = 16;
  localparam int AB = 2;
  localparam int NSEG = 4;

  logic          clk;
  logic          rst_n;
  logic [NB-1:0] in_data;
  logic          in_valid;
  logic          in_ready;
  logic          tick;
  logic [NB-1:0] out_data;
  logic          out_valid;
  logic          underrun;

  int total;
  int bad;

  // Reference model state
  logic          m_hold_valid;
  logic [NB-1:0] m_hold;
  bit            m_has_anchor;
  bit            m_seg;
  longint        m_anchor;
  longint        m_target;
  int            m_k;
  logic [NB-1:0] m_out;
  logic          m_valid;
  logic          m_under;

  int obs_q[$];
  int exp_q[$];
  int under_cnt;

  linear_interpolator #(.NBITS(NB), .ABITS(AB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .tick     (tick),
    .out_data (out_data),
    .out_valid(out_valid),
    .underrun (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic logic [NB-1:0] interp(input longint a, input longint t, input int k);
    longint num;
    num = a * NSEG + (t - a) * k;
    return NB'(num / NSEG);
  endfunction

  task automatic model_reset();
    m_hold_valid = 1'b0;
    m_hold       = '0;
    m_has_anchor = 0;
    m_seg        = 0;
    m_anchor     = 0;
    m_target     = 0;
    m_k          = 0;
    m_out        = '0;
    m_valid      = 1'b0;
    m_under      = 1'b0;
  endtask

  // One clock of the reference: samples queue through a single holding slot,
  // ticks walk k across [anchor, target].
  task automatic model_eval(input logic iv, input logic [NB-1:0] d, input logic tk,
                            output logic accepted);
    logic hv;
    hv       = m_hold_valid;
    accepted = iv && !hv;
    m_valid  = 1'b0;
    m_under  = 1'b0;
    if (!m_has_anchor) begin
      if (hv) begin
        m_anchor     = m_hold;
        m_has_anchor = 1;
        m_hold_valid = 1'b0;
      end
    end else if (!m_seg) begin
      if (tk) begin
        m_valid = 1'b1;
        m_out   = m_anchor[NB-1:0];
      end
      if (hv) begin
        m_target     = m_hold;
        m_hold_valid = 1'b0;
        m_seg        = 1;
        m_k          = tk ? 1 : 0;
      end else if (tk) begin
        m_under = 1'b1;
      end
    end else if (tk) begin
      m_valid = 1'b1;
      m_out   = interp(m_anchor, m_target, m_k);
      m_k++;
      if (m_k == NSEG) begin
        m_anchor = m_target;
        m_k      = 0;
        if (hv) begin
          m_target     = m_hold;
          m_hold_valid = 1'b0;
        end else begin
          m_seg = 0;
        end
      end
    end
    if (accepted) begin
      m_hold_valid = 1'b1;
      m_hold       = d;
    end
  endtask

  task automatic step(input logic iv, input logic [NB-1:0] d, input logic tk,
                      output logic accepted);
    in_valid = iv;
    in_data  = d;
    tick     = tk;
    model_eval(iv, d, tk, accepted);
    @(posedge clk);
    #1;
    check("out_valid", out_valid, m_valid);
    check("underrun", underrun, m_under);
    check("out_data", out_data, m_out);
    check("in_ready", in_ready, !m_hold_valid);
    if (out_valid) obs_q.push_back(int'(out_data));
    if (underrun) under_cnt++;
    in_valid = 1'b0;
    tick     = 1'b0;
  endtask

  task automatic idle(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, a);
  endtask

  task automatic ticks(input int n);
    logic a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, a);
  endtask

  task automatic push(input logic [NB-1:0] d);
    logic a;
    a = 1'b0;
    for (int i = 0; i < 16 && !a; i++) step(1'b1, d, 1'b0, a);
    check("push_accepted", a, 1'b1);
  endtask

  task automatic compare_seq(input string tag);
    check({tag, "_len"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check(tag, obs_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_underrun", underrun, 1'b0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_in_ready", in_ready, 1'b1);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();
    obs_q.delete();
    under_cnt = 0;
  endtask

  initial begin
    logic a;
    int   acc_cnt;
    total    = 0;
    bad      = 0;
    in_valid = 1'b0;
    in_data  = '0;
    tick     = 1'b0;
    under_cnt = 0;
    model_reset();
    #2;

    // Ramp up with hold and underrun
    do_reset();
    ticks(2);
    push(16'd100);
    push(16'd108);
    idle(2);
    ticks(8);
    idle(1);
    exp_q = '{100, 102, 104, 106, 108, 108, 108, 108};
    compare_seq("ramp_up");
    check("ramp_up_underruns", under_cnt, 32'd4);

    // Descending then ascending chained segments
    do_reset();
    push(16'd108);
    push(16'd100);
    push(16'd104);
    ticks(12);
    idle(1);
    exp_q = '{108, 106, 104, 102, 100, 101, 102, 103, 104, 104, 104, 104};
    compare_seq("chain");
    check("chain_underruns", under_cnt, 32'd4);

    // Fractional steps floor
    do_reset();
    push(16'd0);
    push(16'd3);
    ticks(6);
    exp_q = '{0, 0, 1, 2, 3, 3};
    compare_seq("floor");

    // Full-scale swing up and back down
    do_reset();
    push(16'd0);
    push(16'd65535);
    push(16'd0);
    ticks(10);
    exp_q = '{0, 16383, 32767, 49151, 65535, 49151, 32767, 16383, 0, 0};
    compare_seq("full_scale");

    // Backpressure with ticks idle
    do_reset();
    acc_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 16'($urandom), 1'b0, a);
      if (a) acc_cnt++;
    end
    check("bp_accepts", acc_cnt, 32'd3);
    check("bp_in_ready_low", in_ready, 1'b0);
    ticks(4);
    check("bp_in_ready_after_load", in_ready, 1'b1);
    ticks(6);

    // Asynchronous reset in the middle of a segment
    do_reset();
    push(16'd10);
    push(16'd20);
    idle(2);
    ticks(2);
    #2;
    do_reset();
    ticks(3);
    check("post_reset_no_output", obs_q.size(), 32'd0);
    push(16'd40);
    push(16'd44);
    ticks(5);
    exp_q = '{40, 41, 42, 43, 44};
    compare_seq("post_reset");

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      logic [NB-1:0] d;
      case ($urandom_range(0, 3))
        0:       d = 16'd0;
        1:       d = 16'hFFFF;
        default: d = 16'($urandom);
      endcase
      step(1'($urandom_range(0, 1)), d, 1'($urandom_range(0, 2) != 0), a);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
